// File: rtl/txfifo.sv
`default_nettype none
// ============================================================================
// Module   : txfifo
// Purpose  : Byte FIFO plus transmit sequencer placed directly ahead of the
//            UART transmitter. Producers write bytes with a strobe. The
//            sequencer hands the bytes to the transmitter one at a time using
//            its enable/busy handshake, so producers never watch UART busy.
//
// Ports    : i_clk        - system clock, rising edge
//            i_reset_n    - asynchronous active-low reset
//            i_wr         - write strobe, one byte per cycle
//            i_wr_data    - byte to write
//            o_full       - FIFO holds 2^DEPTH_LOG2 entries
//            o_empty      - FIFO holds no entries
//            o_fill       - entry count, 0..2^DEPTH_LOG2
//            o_overflow   - sticky write-while-full flag (optional)
//            o_tx_enable  - launch request to the transmitter
//            o_tx_data    - byte presented to the transmitter
//            i_tx_busy    - transmitter busy
//
// Options  : TXFIFO_OVERFLOW_FLAG_EN - when defined, o_overflow latches any
//            dropped write until reset; otherwise o_overflow is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module txfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr,
    input  logic [7:0]            i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_fill,
    output logic                  o_overflow,
    output logic                  o_tx_enable,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_busy
);

    localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PTR_INC = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [7:0]          r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [7:0]          r_tx_data;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // ------------------------------------------------------------------
    // Status flags. Pointers carry one extra bit so that full and empty
    // are distinguishable when the index bits coincide.
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

    // A pop in the same cycle does not rescue a write against a full FIFO:
    // acceptance looks only at the pre-edge full flag.
    assign w_push  = i_wr && !w_full;

    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_fill  = r_wr_ptr - r_rd_ptr;

    // ------------------------------------------------------------------
    // Storage. The array itself needs no reset; only the pointers define
    // which entries are valid.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_INC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_INC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and pop decision. Only IDLE pops, so every
    // byte is handed to the transmitter exactly once. IDLE also waits for
    // busy to be low, which covers a transmitter still running after a
    // reset of this block.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !i_tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (i_tx_busy) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!i_tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Head byte is captured on the pop edge and held stable through SEND.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_data <= 8'h00;
        end else if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Enable is exactly "in SEND": it rises on the pop edge and falls on
    // the edge that first samples busy high.
    assign o_tx_enable = (r_state == S_SEND);
    assign o_tx_data   = r_tx_data;

    // ------------------------------------------------------------------
    // Optional sticky overflow flag
    // ------------------------------------------------------------------
`ifdef TXFIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow <= 1'b0;
        end else if (i_wr && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`else
    assign o_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_txfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_txfifo
// Purpose  : Self-checking bench for txfifo with a model UART transmitter
//            and a byte scoreboard (written bytes vs. launched bytes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_txfifo;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr      = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] fill;
    logic       overflow;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_busy;

    int         total = 0;
    int         bad   = 0;

    bit         hold_busy = 1'b0;
    int         busy_len  = 10;
    int         busy_cnt  = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    logic       exp_ovf;

    txfifo #(.DEPTH_LOG2(4)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_wr        (wr),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_fill      (fill),
        .o_overflow  (overflow),
        .o_tx_enable (tx_enable),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // Model transmitter: accepts a launch when enable is seen while idle,
    // raises busy on that edge and keeps it high for busy_len cycles.
    assign tx_busy = hold_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (tx_enable && !hold_busy) begin
            busy_cnt <= busy_len;
            rx_q.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for n launches, then compares them in order against
    // the scoreboard.
    task automatic check_rx(input int n, input string tag);
        int waited;
        waited = 0;
        while (rx_q.size() < n && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic settle();
        repeat (busy_len + 5) @(negedge clk);
    endtask

    initial begin
`ifdef TXFIFO_OVERFLOW_FLAG_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_empty",    32'(empty),     32'd1);
        check("rst_full",     32'(full),      32'd0);
        check("rst_fill",     32'(fill),      32'd0);
        check("rst_enable",   32'(tx_enable), 32'd0);
        check("rst_data",     32'(tx_data),   32'h00);
        check("rst_overflow", 32'(overflow),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- basic path ----------------
        wr = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
        @(negedge clk);
        wr = 1'b0;
        check("basic_empty_fall", 32'(empty),     32'd0);
        check("basic_fill1",      32'(fill),      32'd1);
        check("basic_en_early",   32'(tx_enable), 32'd0);
        @(negedge clk);
        check("basic_enable",     32'(tx_enable), 32'd1);
        check("basic_data",       32'(tx_data),   32'h41);
        @(negedge clk);
        check("basic_busy_seen",  32'(tx_busy),   32'd1);
        check("basic_en_hold",    32'(tx_enable), 32'd1);
        @(negedge clk);
        check("basic_en_drop",    32'(tx_enable), 32'd0);
        check_rx(1, "basic_rx");
        settle();
        check("basic_empty_end",  32'(empty),     32'd1);

        // ---------------- fill and drain ----------------
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
            @(negedge clk);
        end
        wr = 1'b0;
        check("fill_full",   32'(full),      32'd1);
        check("fill_fill",   32'(fill),      32'd16);
        check("fill_noen",   32'(tx_enable), 32'd0);

        // ---------------- overflow ----------------
        wr = 1'b1; wr_data = 8'hAA;
        @(negedge clk);
        wr = 1'b0;
        check("ovf_fill",     32'(fill),     32'd16);
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_flag",     32'(overflow), 32'(exp_ovf));
        hold_busy = 1'b0;
        check_rx(16, "drain_rx");
        settle();
        check("drain_empty",  32'(empty),    32'd1);
        check("ovf_sticky",   32'(overflow), 32'(exp_ovf));

        // ---------------- simultaneous write and pop ----------------
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; wr_data = 8'(8'hC0 + i); exp_q.push_back(8'(8'hC0 + i));
            @(negedge clk);
        end
        wr = 1'b0;
        check("sim_fill_pre", 32'(fill), 32'd3);
        hold_busy = 1'b0;
        wr = 1'b1; wr_data = 8'hC3; exp_q.push_back(8'hC3);
        @(negedge clk);
        wr = 1'b0;
        check("sim_fill_post", 32'(fill),      32'd3);
        check("sim_enable",    32'(tx_enable), 32'd1);
        check("sim_data",      32'(tx_data),   32'hC0);
        check_rx(4, "sim_rx");
        settle();

        // ---------------- wrap-around stream ----------------
        busy_len = 2;
        for (int i = 0; i < 40; i++) begin
            int gap;
            int guard;
            logic [7:0] d;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            guard = 0;
            while (full && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            d = 8'($urandom);
            wr = 1'b1; wr_data = d; exp_q.push_back(d);
            @(negedge clk);
            wr = 1'b0;
        end
        check_rx(40, "wrap_rx");
        busy_len = 10;
        settle();
        check("wrap_empty", 32'(empty), 32'd1);

        // ---------------- reset mid-transfer ----------------
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; wr_data = 8'(8'h70 + i);
            @(negedge clk);
        end
        wr = 1'b0;
        check("mid_fill6", 32'(fill), 32'd6);
        hold_busy = 1'b0;
        @(negedge clk);
        check("mid_send_en",   32'(tx_enable), 32'd1);
        check("mid_send_fill", 32'(fill),      32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en",    32'(tx_enable), 32'd0);
        check("mid_rst_fill",  32'(fill),      32'd0);
        check("mid_rst_empty", 32'(empty),     32'd1);
        hold_busy = 1'b1;
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
        @(negedge clk);
        wr = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_wait_en", 32'(tx_enable),   32'd0);
        check("post_rst_fill",    32'(fill),        32'd1);
        check("post_rst_no_rx",   32'(rx_q.size()), 32'd0);
        hold_busy = 1'b0;
        check_rx(1, "post_rst_rx");
        settle();
        check("final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
